// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned ADDR_W      = 64;
  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned FIFO_DEPTH  = 2;
  localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1);

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid FIFO of fetch entries; head is held in flops so the
// consumer sees registered outputs, and an empty head reads {0, EMPTY_INSTR}.
module fetch_skid_fifo
  import fetch_pkg::*;
#(
  parameter logic [INSTR_W-1:0] EMPTY_INSTR = NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  fetch_entry_t       din,
  input  logic               pop,
  output fetch_entry_t       head,
  output logic               head_valid,
  output logic [CNT_W-1:0]   count
);

  localparam fetch_entry_t EMPTY_ENTRY = '{pc: '0, instr: EMPTY_INSTR};

  fetch_entry_t       head_q, head_d;
  fetch_entry_t       tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               valid_q, valid_d;

  // Next-state for head/tail/count under push, pop and flush.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (flush) begin
      head_d  = EMPTY_ENTRY;
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == CNT_W'(0)) head_d = din;
          else                      tail_d = din;
          count_d = count_q + CNT_W'(1);
        end
        2'b01: begin
          head_d  = (count_q == CNT_W'(2)) ? tail_q : EMPTY_ENTRY;
          count_d = count_q - CNT_W'(1);
        end
        2'b11: begin
          if (count_q == CNT_W'(2)) begin
            head_d = tail_q;
            tail_d = din;
          end else begin
            head_d = din;
          end
        end
        default: ;
      endcase
    end
    valid_d = (count_d != CNT_W'(0));
  end

  // Storage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= EMPTY_ENTRY;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign head       = head_q;
  assign head_valid = valid_q;
  assign count      = count_q;

  // Credit accounting upstream must never let a push land on a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && !flush && (count_q == CNT_W'(2))));

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues sequential requests to
// a 1-cycle-latency instruction memory and buffers responses in a skid FIFO.
// Optional macro FETCH_PERF_CNT_EN adds delivered/bubble performance counters.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC  = 64'h0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubbles
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic              kill_q, kill_d;

  logic              pop_c, push_c, issue_c, credit_ok_c;
  logic [CNT_W:0]    occupancy_c, limit_c;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_valid;
  fetch_entry_t      fifo_head, push_entry_c;

  // Issue decision: a slot is free once buffered plus outstanding entries,
  // net of this cycle's pop, fall below the FIFO depth.
  always_comb begin
    pop_c        = fifo_valid & ~stall & ~redirect;
    occupancy_c  = {1'b0, fifo_count} + (CNT_W+1)'(inflight_q);
    limit_c      = (CNT_W+1)'(FIFO_DEPTH) + (CNT_W+1)'(pop_c);
    credit_ok_c  = (occupancy_c < limit_c);
    issue_c      = ~reset & ~redirect & credit_ok_c;
    push_c       = inflight_q & ~kill_q & ~redirect & ~reset;
    push_entry_c = '{pc: inflight_pc_q, instr: imem_rdata};
  end

  // Fetch PC, in-flight tracking and response-kill flag next state.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue_c;
    inflight_pc_d = inflight_pc_q;
    kill_d        = redirect;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (issue_c) begin
      pc_d          = pc_q + ADDR_W'(INSTR_BYTES);
      inflight_pc_d = pc_q;
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      kill_q        <= kill_d;
    end
  end

  fetch_skid_fifo #(
    .EMPTY_INSTR (NOP_INSTR)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect),
    .push       (push_c),
    .din        (push_entry_c),
    .pop        (pop_c),
    .head       (fifo_head),
    .head_valid (fifo_valid),
    .count      (fifo_count)
  );

  assign imem_req  = issue_c;
  assign imem_addr = pc_q;
  assign out_valid = fifo_valid;
  assign out_pc    = fifo_head.pc;
  assign out_instr = fifo_head.instr;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] bubbles_q, bubbles_d;

  // Saturating delivered-instruction and empty-output counters.
  always_comb begin
    fetched_d = fetched_q;
    bubbles_d = bubbles_q;
    if (pop_c && (fetched_q != 32'hFFFF_FFFF)) fetched_d = fetched_q + 32'd1;
    if (!fifo_valid && (bubbles_q != 32'hFFFF_FFFF)) bubbles_d = bubbles_q + 32'd1;
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q <= '0;
      bubbles_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      bubbles_q <= bubbles_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
`else
  assign perf_fetched = '0;
  assign perf_bubbles = '0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit against a queue-based fetch model.
module tb_if_fetch_unit;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam logic [31:0] NOP      = 32'hD503201F;

  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] perf_fetched, perf_bubbles;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: instructions ready at the output, one pending
  // memory response, next address to fetch, and perf totals.
  logic [63:0] q[$];
  bit          pend     = 1'b0;
  logic [63:0] pend_pc  = '0;
  logic [63:0] fpc      = RESET_PC;
  logic [31:0] m_fetched = '0;
  logic [31:0] m_bubbles = '0;

  if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .out_valid    (out_valid),
    .out_pc       (out_pc),
    .out_instr    (out_instr),
    .perf_fetched (perf_fetched),
    .perf_bubbles (perf_bubbles)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [63:0] w;
    w = a >> 2;
    return w[31:0];
  endfunction

  // Memory with 1-cycle read latency; unrequested cycles return junk.
  always @(posedge clk)
    imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hBAD0_BAD0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // One clock cycle: apply inputs, compare against model, advance model.
  task automatic cyc(input bit r, input bit s, input bit rd, input logic [63:0] rp);
    bit m_pop, m_req;
    int occ;
    reset = r; stall = s; redirect = rd; redirect_pc = rp;
    #1;
    m_pop = (q.size() > 0) && !s && !rd && !r;
    occ   = q.size() + int'(pend) - int'(m_pop);
    m_req = !r && !rd && (occ < 2);
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check("out_pc",    out_pc, (q.size() > 0) ? q[0] : 64'h0);
    check("out_instr", 64'(out_instr), 64'((q.size() > 0) ? mem_word(q[0]) : NOP));
    check("imem_req",  64'(imem_req), 64'(m_req));
    if (m_req) check("imem_addr", imem_addr, fpc);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
    check("perf_bubbles", 64'(perf_bubbles), 64'(m_bubbles));
`else
    check("perf_fetched", 64'(perf_fetched), 64'h0);
    check("perf_bubbles", 64'(perf_bubbles), 64'h0);
`endif
    if (r) begin
      m_fetched = '0;
      m_bubbles = '0;
    end else begin
      if (q.size() == 0) m_bubbles++;
      if (m_pop) m_fetched++;
    end
    if (r) begin
      q.delete(); pend = 1'b0; fpc = RESET_PC;
    end else if (rd) begin
      q.delete(); pend = 1'b0; fpc = rp;
    end else begin
      if (m_pop) void'(q.pop_front());
      if (pend) q.push_back(pend_pc);
      pend    = m_req;
      pend_pc = fpc;
      if (m_req) fpc = fpc + 64'd4;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    cyc(1, 0, 0, 0);
    // Clean stream from reset: 0,4,8,C...
    repeat (12) cyc(0, 0, 0, 0);
    // Stall held while streaming, then release.
    repeat (3) cyc(0, 1, 0, 0);
    repeat (4) cyc(0, 0, 0, 0);
    // Fill FIFO under stall, redirect while full and stalled.
    repeat (3) cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 64'h100);
    repeat (6) cyc(0, 0, 0, 0);
    // Back-to-back redirects, last wins.
    cyc(0, 0, 1, 64'h200);
    cyc(0, 0, 1, 64'h300);
    repeat (6) cyc(0, 0, 0, 0);
    // Address wrap through the top of the address space.
    cyc(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF8);
    repeat (6) cyc(0, 0, 0, 0);
    // Reset mid-stream restarts at RESET_PC.
    cyc(1, 0, 0, 0);
    repeat (6) cyc(0, 0, 0, 0);
    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      logic [63:0] rp;
      rp = {$urandom, $urandom} & ~64'h3;
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 19) == 0), rp);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that produces the {PC, instruction} pair consumed by the IF/ID pipeline register in the pipelined 64-bit CPU. It owns the architectural fetch PC and issues sequential requests to a synchronous instruction memory with fixed 1-cycle read latency. It absorbs memory latency with a 2-entry skid FIFO so that hazard stalls never lose an instruction, and it flushes on a taken-branch redirect from later stages.

Parameters:
ADDR_W, 64, PC and instruction-memory address width
INSTR_W, 32, instruction width
RESET_PC, 64'h0, fetch address after reset
NOP_INSTR, 32'hD503201F, encoding driven on out_instr when out_valid=0

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hazard unit: IF/ID must hold; no pop this cycle
redirect  in  1  taken branch/exception: flush and refetch
redirect_pc  in  ADDR_W  new fetch address, valid with redirect
imem_req  out  1  read request this cycle
imem_addr  out  ADDR_W  read address (= pc_q)
imem_rdata  in  INSTR_W  data for the request issued the previous cycle
out_valid  out  1  out_pc/out_instr hold a real instruction
out_pc  out  ADDR_W  PC of the delivered instruction (to IF/ID PCin)
out_instr  out  INSTR_W  delivered instruction (to IF/ID instr)
perf_fetched  out  32  delivered-instruction count (optional feature)
perf_bubbles  out  32  empty-output cycle count (optional feature)

Behaviour:
- Interface decided: single clock clk; reset is synchronous and active-high, named reset.
- Reset values: pc_q=RESET_PC, FIFO count=0, inflight=0, out_valid=0, out_pc=0, out_instr=NOP_INSTR, imem_req=0 during reset, perf counters=0.
- pop = out_valid & ~stall & ~redirect.
- credit = 2 - count - inflight + pop. imem_req = ~reset & ~redirect & (credit>0). imem_addr = pc_q.
- On an issue: pc_q <= pc_q + 4 (mod 2^ADDR_W; wraps silently); inflight <= 1; the issued PC is captured as inflight_pc.
- Cycle after an issue with inflight=1 and no kill: push {inflight_pc, imem_rdata} into the FIFO. Push and pop in the same cycle are legal; count is updated by push-pop.
- Outputs are the registered FIFO head. When count=0: out_valid=0, out_pc=0, out_instr=NOP_INSTR.
- Latency: request in cycle N -> rdata in N+1 -> out_valid in N+2. In steady state with no stall, one instruction is delivered per cycle.
- Full: count=2, or count=1 with inflight=1 and no pop -> no issue. The credit rule makes overflow impossible. Pushing into a full FIFO is an assertion error.
- Empty: stall is ignored for pop purposes; out_valid stays 0.
- Redirect (priority over stall and push): in that cycle, FIFO cleared, no pop, and any inflight response is killed (a kill flag discards next-cycle rdata). pc_q <= redirect_pc and imem_req=0. The first request to redirect_pc issues the next cycle. out_valid=0 for two cycles after the redirect edge.
- Back-to-back redirects: the last one wins.
- Reset mid-operation: the same clearing as redirect, and the fetch restarts at RESET_PC.
- redirect_pc must be 4-byte aligned. A misaligned value is fetched as given; the low 2 bits are not masked.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: perf_fetched increments on every pop. perf_bubbles increments on every non-reset cycle with out_valid=0. Both saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are inferred.

Decomposition:
- Package fetch_pkg: fetch_entry_t struct {pc[ADDR_W], instr[INSTR_W]}, INSTR_BYTES=4, NOP_INSTR constant, FIFO_DEPTH=2.
- Sub-module fetch_skid_fifo: 2-entry FIFO of fetch_entry_t with push/pop/flush, head outputs and count.
- if_fetch_unit contains the PC, credit/issue logic, kill flag and perf counters.

Test Plan:
- Reset release, no stall, memory returns addr>>2 -> out_pc 0,4,8,C on consecutive cycles starting 2 cycles after reset drops; out_instr 0,1,2,3.
- Stall held 3 cycles while streaming -> out_pc frozen at 8; imem_req drops once credit=0; no PC skipped or duplicated after release (8,C,10).
- Redirect to 64'h100 while FIFO full and stall=1 -> out_valid=0 for 2 cycles, next out_pc=100, stale inflight rdata never appears.
- Redirect on two consecutive cycles (200 then 300) -> first delivered out_pc=300.
- pc_q near 64'hFFFFFFFFFFFFFFFC -> next issued address 0; reset asserted mid-stream -> outputs at reset values next cycle, refetch at RESET_PC.
- With FETCH_PERF_CNT_EN: 10 delivered instructions plus one redirect -> perf_fetched=10, perf_bubbles = initial 2 + 2 post-redirect; without the macro -> both ports read 0.
